// File: rtl/risc_run_controller.sv
// Run/step/breakpoint sequencer for the 5-stage RISC core: debounces the board buttons,
// generates the core clock-enable and tracks enabled cycles and the LED byte.
module risc_run_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned RUN_DIV         = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_step,
    input  logic        btn_run,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] core_pc,
    input  logic [31:0] core_result,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic [31:0] cycle_count,
    output logic [7:0]  led
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned DivW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        StHalt  = 2'd0,
        StRun   = 2'd1,
        StStep  = 2'd2,
        StBreak = 2'd3
    } state_e;

    // Bit 1 = run button, bit 0 = step button.
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      stable;
    logic [1:0]      stable_prev;
    logic [1:0]      press;
    logic [CntW-1:0] db_cnt [2];

    state_e          st;
    logic [DivW-1:0] div_cnt;
    logic            bp_skip;
    logic            run_p;
    logic            step_p;
    logic            bp_hit;

    assign run_p  = press[1];
    assign step_p = press[0];
    assign bp_hit = bp_en && (core_pc == bp_addr) && !bp_skip;
    assign state  = st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1       <= '0;
            sync2       <= '0;
            stable      <= '0;
            stable_prev <= '0;
            press       <= '0;
            db_cnt[0]   <= '0;
            db_cnt[1]   <= '0;
        end else begin
            sync1       <= {btn_run, btn_step};
            sync2       <= sync1;
            stable_prev <= stable;
            press       <= stable & ~stable_prev;
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] == stable[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == CntLast) begin
                    stable[b] <= sync2[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= StHalt;
            cpu_en      <= 1'b0;
            div_cnt     <= '0;
            bp_skip     <= 1'b0;
            cycle_count <= '0;
            led         <= '0;
        end else begin
            cpu_en <= 1'b0;
            unique case (st)
                StHalt: begin
                    if (run_p) begin
                        st      <= StRun;
                        div_cnt <= '0;
                    end else if (step_p) begin
                        st     <= StStep;
                        cpu_en <= 1'b1;
                    end
                end
                StRun: begin
                    // A halt press wins over an enable falling due on the same edge.
                    if (run_p) begin
                        st <= StHalt;
                    end else if (div_cnt == DivLast) begin
                        div_cnt <= '0;
                        if (bp_hit) begin
                            st <= StBreak;
                        end else begin
                            cpu_en  <= 1'b1;
                            bp_skip <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                StStep: begin
                    st <= StHalt;
                end
                StBreak: begin
                    // Resuming skips the breakpoint once so the core can leave the PC.
                    if (run_p) begin
                        st      <= StRun;
                        div_cnt <= '0;
                        bp_skip <= 1'b1;
                    end else if (step_p) begin
                        st     <= StStep;
                        cpu_en <= 1'b1;
                    end
                end
                default: st <= StHalt;
            endcase

            if (cpu_en) begin
                if (cycle_count != '1) begin
                    cycle_count <= cycle_count + 1'b1;
                end
                led <= core_result[7:0];
            end
        end
    end

endmodule

// File: tb/tb_risc_run_controller.sv
// Directed bench for risc_run_controller with DEBOUNCE_CYCLES=16, RUN_DIV=4.
module tb_risc_run_controller;

    localparam int unsigned DB  = 16;
    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_step = 1'b0;
    logic        btn_run = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = '0;
    logic [31:0] core_pc = '0;
    logic [31:0] core_result = '0;
    logic        cpu_en;
    logic [1:0]  state;
    logic [31:0] cycle_count;
    logic [7:0]  led;

    int checks = 0;
    int errors = 0;

    risc_run_controller #(
        .DEBOUNCE_CYCLES (DB),
        .RUN_DIV         (DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_step    (btn_step),
        .btn_run     (btn_run),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .core_pc     (core_pc),
        .core_result (core_result),
        .cpu_en      (cpu_en),
        .state       (state),
        .cycle_count (cycle_count),
        .led         (led)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Press, hold 30 cycles, release and let the release settle.
    task automatic tap(input bit run, input bit step);
        btn_run = run;
        btn_step = step;
        repeat (30) @(negedge clk);
        btn_run = 1'b0;
        btn_step = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got %0b want 0", cpu_en); end
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0h want 0", cycle_count); end
        checks++; if (led !== 8'd0) begin errors++; $display("FAIL reset_led got %0h want 0", led); end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (state !== 2'd0 || cpu_en !== 1'b0) begin
            errors++; $display("FAIL post_reset got state=%0d en=%0b want 0/0", state, cpu_en);
        end
    endtask

    task automatic test_step();
        int en_cnt = 0;
        int first_en = -1;
        bit saw_step = 0;
        bit en_in_step = 1;
        core_result = 32'h1234_56C3;
        btn_step = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (cpu_en) begin
                en_cnt++;
                if (first_en < 0) first_en = i;
                if (state != 2'd2) en_in_step = 0;
            end
            if (state == 2'd2) saw_step = 1;
            if (i == 30) btn_step = 1'b0;
        end
        checks++; if (en_cnt !== 1) begin errors++; $display("FAIL step_pulses got %0d want 1", en_cnt); end
        checks++; if (first_en !== int'(DB) + 4) begin
            errors++; $display("FAIL step_latency got %0d want %0d", first_en, DB + 4);
        end
        checks++; if (!saw_step || !en_in_step) begin
            errors++; $display("FAIL step_state got saw=%0b en_in_step=%0b want 1/1", saw_step, en_in_step);
        end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL step_return got %0d want 0", state); end
        checks++; if (cycle_count !== 32'd1) begin errors++; $display("FAIL step_count got %0d want 1", cycle_count); end
        checks++; if (led !== 8'hC3) begin errors++; $display("FAIL step_led got %0h want c3", led); end
    endtask

    task automatic test_glitch();
        int en_cnt = 0;
        int bad_state = 0;
        logic [31:0] cc0 = cycle_count;
        btn_run = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (cpu_en) en_cnt++;
            if (state != 2'd0) bad_state++;
            if (i == 10) btn_run = 1'b0;
        end
        checks++; if (en_cnt !== 0) begin errors++; $display("FAIL glitch_en got %0d want 0", en_cnt); end
        checks++; if (bad_state !== 0) begin errors++; $display("FAIL glitch_state got %0d want 0", bad_state); end
        checks++; if (cycle_count !== cc0) begin errors++; $display("FAIL glitch_count got %0h want %0h", cycle_count, cc0); end
    endtask

    task automatic test_run();
        logic [31:0] cc0 = cycle_count;
        int total = 0;
        int run_at = -1;
        int first_en = -1;
        int prev = -1;
        int bad_gap = 0;
        int en1 = 0;
        int en2 = 0;
        int last_en = -1;
        int late_run = 0;
        btn_run = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (state == 2'd1 && run_at < 0) run_at = i;
            if (cpu_en) begin
                en1++;
                total++;
                if (first_en < 0) first_en = i;
                if (prev >= 0 && i - prev != int'(DIV)) bad_gap++;
                prev = i;
            end
            if (i == 30) btn_run = 1'b0;
        end
        checks++; if (run_at !== 20) begin errors++; $display("FAIL run_entry got %0d want 20", run_at); end
        checks++; if (first_en !== 24) begin errors++; $display("FAIL run_first_en got %0d want 24", first_en); end
        checks++; if (en1 !== 10) begin errors++; $display("FAIL run_pulses got %0d want 10", en1); end
        checks++; if (bad_gap !== 0) begin errors++; $display("FAIL run_spacing got %0d bad gaps want 0", bad_gap); end
        // Halt press lands on the edge where an enable is due: halt must win.
        btn_run = 1'b1;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (cpu_en) begin
                en2++;
                total++;
                last_en = j;
            end
            if (j >= 20 && state != 2'd0) late_run++;
            if (j == 30) btn_run = 1'b0;
        end
        checks++; if (en2 !== 4) begin errors++; $display("FAIL halt_pulses got %0d want 4", en2); end
        checks++; if (last_en !== 16) begin errors++; $display("FAIL halt_wins got last=%0d want 16", last_en); end
        checks++; if (late_run !== 0) begin errors++; $display("FAIL halt_state got %0d non-halt want 0", late_run); end
        checks++; if (cycle_count - cc0 !== 32'(total)) begin
            errors++; $display("FAIL run_count got %0d want %0d", cycle_count - cc0, total);
        end
    endtask

    task automatic test_breakpoint();
        int en_cnt = 0;
        int first_en = -1;
        bit pc_ok = 0;
        bp_en = 1'b1;
        bp_addr = 32'h0000_0010;
        core_pc = 32'h0000_0000;
        btn_run = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (cpu_en) en_cnt++;
            if (i == 30) begin
                btn_run = 1'b0;
                core_pc = 32'h0000_0010;
            end
        end
        checks++; if (en_cnt !== 2) begin errors++; $display("FAIL bp_pulses got %0d want 2", en_cnt); end
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL bp_state got %0d want 3", state); end
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL bp_cpu_en got %0b want 0", cpu_en); end
        en_cnt = 0;
        btn_run = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (cpu_en) begin
                en_cnt++;
                if (first_en < 0) begin
                    first_en = i;
                    pc_ok = (core_pc == 32'h0000_0010);
                    core_pc = 32'h0000_0014;
                end
            end
            if (i == 30) btn_run = 1'b0;
        end
        checks++; if (first_en !== 24 || !pc_ok) begin
            errors++; $display("FAIL bp_resume got first=%0d pc_ok=%0b want 24/1", first_en, pc_ok);
        end
        checks++; if (en_cnt !== 10) begin errors++; $display("FAIL bp_continue got %0d want 10", en_cnt); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL bp_run_state got %0d want 1", state); end
        tap(1'b1, 1'b0);
        bp_en = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL bp_halt got %0d want 0", state); end
    endtask

    task automatic test_simultaneous();
        bit saw_step = 0;
        btn_run = 1'b1;
        btn_step = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (state == 2'd2) saw_step = 1;
            if (i == 30) begin
                btn_run = 1'b0;
                btn_step = 1'b0;
            end
        end
        checks++; if (saw_step !== 1'b0 || state !== 2'd1) begin
            errors++; $display("FAIL simul_press got state=%0d saw_step=%0b want 1/0", state, saw_step);
        end
        btn_step = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (state != 2'd1) saw_step = 1;
            if (i == 30) btn_step = 1'b0;
        end
        checks++; if (saw_step !== 1'b0) begin errors++; $display("FAIL step_in_run got left_run=1 want 0"); end
        tap(1'b1, 1'b0);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL simul_halt got %0d want 0", state); end
    endtask

    task automatic test_saturation_reset();
        int en_cnt = 0;
        int k = 0;
        int bad = 0;
        core_result = 32'h0000_005A;
        @(negedge clk);
        force dut.cycle_count = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.cycle_count;
        @(negedge clk);
        checks++; if (cycle_count !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL count_hold got %0h want fffffffe", cycle_count);
        end
        btn_run = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (cpu_en) en_cnt++;
            if (i == 30) btn_run = 1'b0;
        end
        checks++; if (en_cnt < 3) begin errors++; $display("FAIL sat_pulses got %0d want >=3", en_cnt); end
        checks++; if (cycle_count !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sat_count got %0h want ffffffff", cycle_count);
        end
        checks++; if (led !== 8'h5A) begin errors++; $display("FAIL sat_led got %0h want 5a", led); end
        while (!cpu_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL wait_en got %0b want 1", cpu_en); end
        #1 reset = 1'b0;
        #1;
        checks++; if (state !== 2'd0 || cpu_en !== 1'b0) begin
            errors++; $display("FAIL async_reset got state=%0d en=%0b want 0/0", state, cpu_en);
        end
        checks++; if (cycle_count !== 32'd0 || led !== 8'd0) begin
            errors++; $display("FAIL async_reset_cnt got cnt=%0h led=%0h want 0/0", cycle_count, led);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (cpu_en || state != 2'd0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL reset_release got %0d active cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_run();
        test_breakpoint();
        test_simultaneous();
        test_saturation_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
